// File: rtl/nibble_serial_incrementer.sv
// Multi-cycle WIDTH-bit incrementer. It processes one 4-bit nibble per clock through a
// carry-increment slice, and a ripple carry register links the nibbles.
// It has a valid/ready handshake on the input and on the output.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    operand handshake; in_data is operand A, in_cin is the increment bit
//   out_valid/out_ready  result handshake; out_sum = A + in_cin mod 2^WIDTH, out_cout = MSB carry
//   busy                 high while an operation is in flight (RUN or DONE)
//
// Optional feature: define NSI_EARLY_EXIT_EN to finish as soon as a nibble produces no carry.
// Results are identical in both builds; only the latency differs.
module nibble_serial_incrementer #(
  parameter int unsigned WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // 4-bit carry-increment slice: {carry_out, nibble + carry_in}
  function automatic logic [4:0] inc4(input logic [3:0] a, input logic c);
    return {1'b0, a} + {4'b0000, c};
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [4:0]        nib_res;
  logic              last_nib;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    nib_res  = inc4(work_q[{idx_q, 2'b00} +: 4], carry_q);
    last_nib = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[{idx_q, 2'b00} +: 4] = nib_res[3:0];
        carry_d  = nib_res[4];
        idx_d    = idx_q + IdxW'(1);
        last_nib = (idx_q == LastIdx);
`ifdef NSI_EARLY_EXIT_EN
        // Without a carry the upper nibbles still hold in_data, which is already the answer.
        if (!nib_res[4]) last_nib = 1'b1;
`endif
        if (last_nib) begin
          state_d = StDone;
          idx_d   = '0;
          // Result registers are loaded only here so they hold their value outside DONE.
          sum_d   = work_d;
          cout_d  = nib_res[4];
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_incrementer.sv
// Self-checking bench for nibble_serial_incrementer (WIDTH=16): a vector table, hand-written
// corner sequences (reset mid-run, in_valid during RUN), and randomized operands checked
// against an arithmetic reference model.
module tb_nibble_serial_incrementer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;

  nibble_serial_incrementer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  // Reference: plain arithmetic for the result, nibble scan for the latency.
  function automatic logic [W:0] model_sum(input logic [W-1:0] d, input logic c);
    return {1'b0, d} + (W + 1)'(c);
  endfunction

  function automatic int model_lat(input logic [W-1:0] d, input logic c);
`ifdef NSI_EARLY_EXIT_EN
    logic [W-1:0] t;
    if (!c) return 1;
    t = d;
    for (int i = 0; i < W / 4; i++) begin
      if (t[3:0] != 4'hF) return i + 1;
      t = t >> 4;
    end
    return W / 4;
`else
    return W / 4;
`endif
  endfunction

  // Offer one operand, measure latency, hold out_ready low for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [W-1:0] d, input logic c, input int hold,
                        input logic [W-1:0] e_sum, input logic e_cout, input int e_lat);
    int n;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " sum"}, out_sum, e_sum);
    chk({tag, " cout"}, out_cout, e_cout);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold sum"}, out_sum, e_sum);
      chk({tag, " hold in_ready"}, in_ready, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " idle in_ready"}, in_ready, 1);
    chk({tag, " idle out_valid"}, out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int           hold;
    logic [W-1:0] e_sum;
    logic         e_cout;
    int           lat_fixed;
    int           lat_early;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] d;
    logic         c;
    logic [W:0]   m;
    int           lat;
    int           e_lat;

    vecs[0] = '{16'h00FF, 1'b1, 0, 16'h0100, 1'b0, 4, 3};
    vecs[1] = '{16'hFFFF, 1'b1, 0, 16'h0000, 1'b1, 4, 4};
    vecs[2] = '{16'h1234, 1'b0, 0, 16'h1234, 1'b0, 4, 1};
    vecs[3] = '{16'h0FFF, 1'b1, 5, 16'h1000, 1'b0, 4, 4};
    vecs[4] = '{16'h000F, 1'b1, 1, 16'h0010, 1'b0, 4, 2};
    vecs[5] = '{16'hFFFE, 1'b1, 0, 16'hFFFF, 1'b0, 4, 1};
    vecs[6] = '{16'h0000, 1'b1, 2, 16'h0001, 1'b0, 4, 1};
    vecs[7] = '{16'hFFFF, 1'b0, 0, 16'hFFFF, 1'b0, 4, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_cout", out_cout, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
`ifdef NSI_EARLY_EXIT_EN
      e_lat = vecs[i].lat_early;
`else
      e_lat = vecs[i].lat_fixed;
`endif
      run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].c, vecs[i].hold,
             vecs[i].e_sum, vecs[i].e_cout, e_lat);
    end

    // Reset in the middle of RUN: outputs go to reset values without a clock edge.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_cin   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("run busy", busy, 1);
    chk("run in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort out_sum", out_sum, 0);
    chk("abort out_cout", out_cout, 0);
    @(negedge clk) rst = 1'b0;
    run_op("post-abort", 16'h0FFF, 1'b1, 0, 16'h1000, 1'b0, model_lat(16'h0FFF, 1'b1));

    // in_valid with new data during RUN must not disturb the operation in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    in_cin   = 1'b1;
    @(posedge clk);
    #1 in_data = 16'hAAAA;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("overlap in_ready", in_ready, 0);
      @(posedge clk);
      #1 lat++;
    end
    chk("overlap latency", lat, model_lat(16'h00FF, 1'b1));
    chk("overlap sum", out_sum, 16'h0100);
    chk("overlap cout", out_cout, 0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("no re-accept in_ready", in_ready, 1);
    chk("no re-accept busy", busy, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("second accept busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("second latency", lat, model_lat(16'hAAAA, 1'b1));
    chk("second sum", out_sum, 16'hAAAB);
    chk("second cout", out_cout, 0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Randomized operands, biased towards runs of all-ones low nibbles.
    for (int k = 0; k < 150; k++) begin
      d = W'($urandom);
      if ($urandom_range(0, 2) == 0) d = d | W'((32'h1 << (4 * $urandom_range(1, 4))) - 1);
      c = 1'($urandom_range(0, 1));
      m = model_sum(d, c);
      run_op($sformatf("rand%0d %h+%0d", k, d, c), d, c, $urandom_range(0, 3),
             m[W-1:0], m[W], model_lat(d, c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
